// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient on Lo, remainder on Hi.
// Optional macro SEQ_DIVIDER_DIVZERO_FAST_EN: divide-by-zero finishes without iterating.
module seq_divider #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi,
  output logic             DivZero,
  output logic [1:0]       dbg_state
);

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] src1_raw;
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  // Handshake: Start is only sampled while Busy=0 (IDLE or DONE); Done is a
  // one-cycle pulse and Lo/Hi/DivZero are valid from that cycle until the next result.
  logic             supported;
  logic             is_signed;
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;
  logic [WIDTH:0]   sh_rem;
  logic [WIDTH:0]   dvsr_ext;
  logic [WIDTH:0]   diff;
  logic             take;

  always_comb begin
    supported = (Funct == FUNCT_DIV) || (Funct == FUNCT_DIVU);
    is_signed = (Funct == FUNCT_DIV);
    src1_neg  = is_signed & Src1[WIDTH-1];
    src2_neg  = is_signed & Src2[WIDTH-1];
    src1_mag  = src1_neg ? -Src1 : Src1;
    src2_mag  = src2_neg ? -Src2 : Src2;
  end

  // The shifted partial remainder can exceed WIDTH bits for large unsigned divisors.
  always_comb begin
    sh_rem   = {rem, quo[WIDTH-1]};
    dvsr_ext = {1'b0, dvsr};
    diff     = sh_rem - dvsr_ext;
    take     = (sh_rem >= dvsr_ext);
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      src1_raw <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Lo       <= '0;
      Hi       <= '0;
      DivZero  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        CALC: begin
          if (take) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= sh_rem[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (dz) begin
            Lo      <= '1;
            Hi      <= src1_raw;
            DivZero <= 1'b1;
          end else begin
            Lo      <= q_neg ? -quo : quo;
            Hi      <= r_neg ? -rem : rem;
            DivZero <= 1'b0;
          end
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back issue.
          state <= IDLE;
          if (Start) begin
            if (!supported) begin
              Lo      <= '0;
              Hi      <= '0;
              DivZero <= 1'b0;
              Done    <= 1'b1;
              state   <= DONE;
            end
`ifdef SEQ_DIVIDER_DIVZERO_FAST_EN
            else if (Src2 == '0) begin
              Lo      <= '1;
              Hi      <= Src1;
              DivZero <= 1'b1;
              Done    <= 1'b1;
              state   <= DONE;
            end
`endif
            else begin
              src1_raw <= Src1;
              quo      <= src1_mag;
              rem      <= '0;
              dvsr     <= src2_mag;
              q_neg    <= src1_neg ^ src2_neg;
              r_neg    <= src1_neg;
              dz       <= (Src2 == '0);
              cnt      <= CNT_W'(WIDTH);
              Busy     <= 1'b1;
              state    <= CALC;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32) with hand-computed quotient/remainder vectors.
module tb_seq_divider;

  localparam int W        = 32;
  localparam int CALC_LAT = W + 1;
`ifdef SEQ_DIVIDER_DIVZERO_FAST_EN
  localparam int DZ_LAT   = 0;
  localparam logic DZ_BUSY = 1'b0;
`else
  localparam int DZ_LAT   = CALC_LAT;
  localparam logic DZ_BUSY = 1'b1;
`endif
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         Start = 1'b0;
  logic [5:0]   Funct = 6'd0;
  logic [W-1:0] Src1  = '0;
  logic [W-1:0] Src2  = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Lo;
  logic [W-1:0] Hi;
  logic         DivZero;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*W:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Funct(Funct),
    .Src1(Src1), .Src2(Src2), .Busy(Busy), .Done(Done),
    .Lo(Lo), .Hi(Hi), .DivZero(DivZero), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // driver: present a request at a falling edge; returns just after edge 0
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    Funct = f;
    Src1  = a;
    Src2  = b;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    Funct = 6'($urandom_range(0, 63));
    Src1  = $urandom;
    Src2  = $urandom;
  endtask

  task automatic expect_res(input logic dz, input logic [W-1:0] hi, input logic [W-1:0] lo);
    exp_q.push_back({dz, hi, lo});
  endtask

  // scoreboard: waits for Done and compares against the oldest expected result
  task automatic wait_done(input string tag, input int exp_lat, input logic exp_busy);
    int lat;
    logic [2*W:0] e;
    check({tag, ".busy0"}, 64'(Busy), 64'(exp_busy));
    lat = 0;
    while (!Done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_at_done"}, 64'(Busy), 64'd0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, ".lo"}, 64'(Lo), 64'(e[W-1:0]));
    check({tag, ".hi"}, 64'(Hi), 64'(e[2*W-1:W]));
    check({tag, ".dz"}, 64'(DivZero), 64'(e[2*W]));
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check({tag, ".done_width"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int done_seen;
    #1 rst_n = 1'b0;
    #20;
    check("reset.busy", 64'(Busy), 64'd0);
    check("reset.done", 64'(Done), 64'd0);
    check("reset.lo", 64'(Lo), 64'd0);
    check("reset.hi", 64'(Hi), 64'd0);
    check("reset.dz", 64'(DivZero), 64'd0);
    check("reset.state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    expect_res(1'b0, 32'h0, 32'hC);
    issue(F_DIVU, 32'h1800, 32'h200);
    wait_done("divu_1800_200", CALC_LAT, 1'b1);
    check_pulse_end("divu_1800_200");

    expect_res(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7_2", CALC_LAT, 1'b1);
    @(negedge clk);

    expect_res(1'b0, 32'h1, 32'hFFFFFFFD);
    issue(F_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done("div_7_m2", CALC_LAT, 1'b1);
    @(negedge clk);

    expect_res(1'b0, 32'h0, 32'h80000000);
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", CALC_LAT, 1'b1);
    @(negedge clk);

    expect_res(1'b0, 32'h80000000, 32'h0);
    issue(F_DIVU, 32'h80000000, 32'hFFFFFFFF);
    wait_done("divu_big", CALC_LAT, 1'b1);
    @(negedge clk);

    expect_res(1'b0, 32'hFFFFFFFE, 32'hFFFFFFF2);
    issue(F_DIV, 32'hFFFFFF9C, 32'd7);
    wait_done("div_m100_7", CALC_LAT, 1'b1);
    @(negedge clk);

    expect_res(1'b0, 32'h0, 32'hFFFFFFFF);
    issue(F_DIVU, 32'hFFFFFFFF, 32'd1);
    wait_done("divu_max_1", CALC_LAT, 1'b1);
    @(negedge clk);

    expect_res(1'b1, 32'h1234, 32'hFFFFFFFF);
    issue(F_DIVU, 32'h1234, 32'h0);
    wait_done("divu_dz", DZ_LAT, DZ_BUSY);
    check_pulse_end("divu_dz");

    expect_res(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF);
    issue(F_DIV, 32'hFFFFFFF9, 32'h0);
    wait_done("div_dz_neg", DZ_LAT, DZ_BUSY);
    @(negedge clk);

    expect_res(1'b0, 32'h0, 32'h0);
    issue(6'b000000, 32'h10, 32'h20);
    wait_done("unsupported", 0, 1'b0);
    check_pulse_end("unsupported");

    // second Start while busy must be dropped
    expect_res(1'b0, 32'h0, 32'hC);
    issue(F_DIVU, 32'h1800, 32'h200);
    repeat (4) @(negedge clk);
    Funct = F_DIV;
    Src1  = 32'd99;
    Src2  = 32'd3;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done("start_while_busy", CALC_LAT - 5, 1'b1);
    check_pulse_end("start_while_busy");

    // back-to-back: next Start presented in the Done cycle
    expect_res(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("b2b_first", CALC_LAT, 1'b1);
    expect_res(1'b0, 32'hF, 32'hFFF);
    issue(F_DIVU, 32'hFFFF, 32'h10);
    wait_done("b2b_second", CALC_LAT, 1'b1);
    check_pulse_end("b2b_second");

    // asynchronous reset mid-operation
    issue(F_DIVU, 32'h5555, 32'd3);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.busy", 64'(Busy), 64'd0);
    check("midrst.done", 64'(Done), 64'd0);
    check("midrst.lo", 64'(Lo), 64'd0);
    check("midrst.hi", 64'(Hi), 64'd0);
    check("midrst.dz", 64'(DivZero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done) done_seen++;
    end
    check("midrst.no_done", 64'(done_seen), 64'd0);

    expect_res(1'b0, 32'd2, 32'd14);
    issue(F_DIVU, 32'd100, 32'd7);
    wait_done("after_rst_100_7", CALC_LAT, 1'b1);
    check_pulse_end("after_rst_100_7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
